select_rd_align: RTL and testbench

Load-data alignment and extension stage of the RISC-V core's memory read path. Takes the raw 32-bit word returned by data memory and selects the addressed byte, halfword or word using the load type and low address bits. It then sign- or zero-extends the selection to produce the value written back to rd. It also flags misaligned or illegal accesses with a registered one-cycle error pulse.

---
 rtl/select_rd_align.sv | 112 +++++++++++
 tb/tb_select_rd_align.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/select_rd_align.sv
// select_rd_align: load-data alignment and extension for the memory read path.
//
// Selects the addressed byte / halfword / word from the raw 32-bit memory word,
// sign- or zero-extends it for writeback, and raises a registered one-cycle
// error pulse for misaligned accesses or illegal load types.
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous active-high reset
//   rdata        raw little-endian memory word (lane0 = bits 7:0)
//   sel_type     load type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, others illegal
//   sel_addr_old low two address bits, already aligned with rdata
//   rd_mem       aligned/extended load result
//   misalign_err error flag for the access presented one cycle earlier
//
// Build option:
//   SELECT_RD_REG_OUT_EN  when defined, rd_mem is registered (1-cycle latency,
//                         resets to zero) and lines up with misalign_err.

module select_rd_align #(
  parameter int unsigned REG_LEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_LEN-1:0] rdata,
  input  logic [2:0]         sel_type,
  input  logic [1:0]         sel_addr_old,
  output logic [REG_LEN-1:0] rd_mem,
  output logic               misalign_err
);

  // The lane selection and extension below are written for a 32-bit datapath.
  if (REG_LEN != 32) begin : gen_bad_reg_len
    $error("select_rd_align: REG_LEN must be 32");
  end

  localparam logic [2:0] SelLb  = 3'b000;
  localparam logic [2:0] SelLh  = 3'b001;
  localparam logic [2:0] SelLw  = 3'b010;
  localparam logic [2:0] SelLbu = 3'b011;
  localparam logic [2:0] SelLhu = 3'b100;

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [REG_LEN-1:0] rd_comb;
  logic               err_now;
  logic               err_q;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (sel_addr_old)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Bit 0 of the address plays no part in halfword data selection.
    half_sel = sel_addr_old[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    rd_comb = '0;
    err_now = 1'b0;
    case (sel_type)
      SelLb:  rd_comb = {{24{byte_sel[7]}}, byte_sel};
      SelLbu: rd_comb = {24'h0, byte_sel};
      SelLh: begin
        rd_comb = {{16{half_sel[15]}}, half_sel};
        err_now = sel_addr_old[0];
      end
      SelLhu: begin
        rd_comb = {16'h0, half_sel};
        err_now = sel_addr_old[0];
      end
      SelLw: begin
        rd_comb = rdata;
        err_now = (sel_addr_old != 2'b00);
      end
      default: begin
        rd_comb = '0;
        err_now = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_now;
    end
  end

  assign misalign_err = err_q;

`ifdef SELECT_RD_REG_OUT_EN
  logic [REG_LEN-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_comb;
    end
  end

  assign rd_mem = rd_q;
`else
  assign rd_mem = rd_comb;
`endif

endmodule

// File: tb/tb_select_rd_align.sv
// Self-checking bench for select_rd_align: directed vectors with hand-written
// expectations followed by randomized vectors checked against a reference model.
// The driver queues one expected response per cycle; the monitor pops and
// compares once per cycle, applying the output latency of the build.

module tb_select_rd_align;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        rst;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  typ;
    logic [1:0]  addr;
    logic        rst;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] rdata;
  logic [2:0]  sel_type;
  logic [1:0]  sel_addr_old;
  logic [31:0] rd_mem;
  logic        misalign_err;

  int checks;
  int errors;
  exp_t q[$];

  select_rd_align #(
    .REG_LEN(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdata       (rdata),
    .sel_type    (sel_type),
    .sel_addr_old(sel_addr_old),
    .rd_mem      (rd_mem),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pick lanes by shifting, extend by arithmetic on the value.
  function automatic exp_t model(input logic [31:0] d, input logic [2:0] t,
                                 input logic [1:0] a, input logic r);
    exp_t        e;
    int unsigned b;
    int unsigned h;
    int unsigned sh;
    b  = (d >> (8 * int'(a))) & 32'hFF;
    sh = a[1] ? 16 : 0;
    h  = (d >> sh) & 32'hFFFF;
    e.rst = r;
    case (t)
      3'd0:    e.rd = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd3:    e.rd = b;
      3'd1:    e.rd = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    e.rd = h;
      3'd2:    e.rd = d;
      default: e.rd = 32'h0;
    endcase
    e.err = (t > 3'd4) || ((t == 3'd1 || t == 3'd4) && a[0]) || (t == 3'd2 && a != 2'd0);
    return e;
  endfunction

  vec_t dir[$] = '{
    '{32'h0000_0000, 3'd2, 2'd0, 1'b1, 32'h0000_0000, 1'b0},
    '{32'h0000_0000, 3'd2, 2'd0, 1'b1, 32'h0000_0000, 1'b0},
    '{32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'h0000_0078, 1'b0},
    '{32'h1234_5678, 3'd0, 2'd1, 1'b0, 32'h0000_0056, 1'b0},
    '{32'h1234_5678, 3'd0, 2'd2, 1'b0, 32'h0000_0034, 1'b0},
    '{32'h1234_5678, 3'd0, 2'd3, 1'b0, 32'h0000_0012, 1'b0},
    '{32'h1234_5678, 3'd1, 2'd0, 1'b0, 32'h0000_5678, 1'b0},
    '{32'h1234_5678, 3'd1, 2'd2, 1'b0, 32'h0000_1234, 1'b0},
    '{32'h1234_5678, 3'd2, 2'd0, 1'b0, 32'h1234_5678, 1'b0},
    '{32'h1234_5678, 3'd3, 2'd0, 1'b0, 32'h0000_0078, 1'b0},
    '{32'h1234_5678, 3'd3, 2'd1, 1'b0, 32'h0000_0056, 1'b0},
    '{32'h1234_5678, 3'd3, 2'd2, 1'b0, 32'h0000_0034, 1'b0},
    '{32'h1234_5678, 3'd3, 2'd3, 1'b0, 32'h0000_0012, 1'b0},
    '{32'h1234_5678, 3'd4, 2'd0, 1'b0, 32'h0000_5678, 1'b0},
    '{32'h1234_5678, 3'd4, 2'd2, 1'b0, 32'h0000_1234, 1'b0},
    '{32'h00FF_0000, 3'd0, 2'd2, 1'b0, 32'hFFFF_FFFF, 1'b0},
    '{32'h00FF_0000, 3'd3, 2'd2, 1'b0, 32'h0000_00FF, 1'b0},
    '{32'h8000_0000, 3'd1, 2'd2, 1'b0, 32'hFFFF_8000, 1'b0},
    '{32'h8000_0000, 3'd4, 2'd2, 1'b0, 32'h0000_8000, 1'b0},
    '{32'h1234_5678, 3'd1, 2'd1, 1'b0, 32'h0000_5678, 1'b1},
    '{32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'h0000_0078, 1'b0},
    '{32'h1234_5678, 3'd2, 2'd3, 1'b0, 32'h1234_5678, 1'b1},
    '{32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'h0000_0078, 1'b0},
    '{32'h1234_5678, 3'd7, 2'd0, 1'b0, 32'h0000_0000, 1'b1},
    '{32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'h0000_0078, 1'b0},
    '{32'h1234_5678, 3'd2, 2'd1, 1'b1, 32'h1234_5678, 1'b1},
    '{32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'h0000_0078, 1'b0},
    '{32'h1234_5678, 3'd5, 2'd0, 1'b0, 32'h0000_0000, 1'b1},
    '{32'h1234_5678, 3'd1, 2'd3, 1'b0, 32'h0000_1234, 1'b1},
    '{32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'h0000_0078, 1'b0},
    '{32'h1234_5678, 3'd0, 2'd3, 1'b0, 32'h0000_0012, 1'b0},
    '{32'h1234_5678, 3'd6, 2'd2, 1'b1, 32'h0000_0000, 1'b1},
    '{32'h1234_5678, 3'd0, 2'd0, 1'b0, 32'h0000_0078, 1'b0}
  };

  task automatic drive(input logic [31:0] d, input logic [2:0] t, input logic [1:0] a,
                       input logic r, input exp_t e);
    @(posedge clk);
    #1;
    rdata        = d;
    sel_type     = t;
    sel_addr_old = a;
    rst          = r;
    q.push_back(e);
  endtask

  // Monitor: data is due this cycle (combinational) or one cycle later
  // (registered); the error flag is always the previous access, cleared by reset.
  initial begin : monitor
    exp_t        prev;
    exp_t        cur;
    logic [31:0] want_rd;
    logic        want_err;
    prev = '{32'h0, 1'b0, 1'b1};
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        cur = q.pop_front();
`ifdef SELECT_RD_REG_OUT_EN
        want_rd = prev.rst ? 32'h0 : prev.rd;
`else
        want_rd = cur.rd;
`endif
        want_err = prev.rst ? 1'b0 : prev.err;
        checks++;
        if (rd_mem !== want_rd) begin
          errors++;
          $display("FAIL rd_mem t=%0t got %08h want %08h", $time, rd_mem, want_rd);
        end
        checks++;
        if (misalign_err !== want_err) begin
          errors++;
          $display("FAIL misalign_err t=%0t got %0b want %0b", $time, misalign_err, want_err);
        end
        prev = cur;
      end
    end
  end

  initial begin : driver
    exp_t e;
    int   guard;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    rdata        = 32'h0;
    sel_type     = 3'd2;
    sel_addr_old = 2'd0;

    foreach (dir[i]) begin
      e = '{dir[i].rd, dir[i].err, dir[i].rst};
      drive(dir[i].rdata, dir[i].typ, dir[i].addr, dir[i].rst, e);
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      logic [2:0]  t;
      logic [1:0]  a;
      logic        r;
      d = $urandom;
      t = 3'($urandom_range(0, 7));
      a = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 19) == 0);
      drive(d, t, a, r, model(d, t, a, r));
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
